// File: rtl/prn_ram_loader.sv
// prn_ram_loader: unpacks a stream of code words into 1-bit PRN RAM writes.
// Each accepted WORD_W-bit word is written LSB-first, one bit per cycle, at
// incrementing addresses 0..length-1.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   start, abort         1-cycle control pulses
//   length               number of code bits to load (sampled on start)
//   s_data/s_valid       code word stream input
//   s_ready              word accepted this cycle (state decode)
//   ram_we/addr/din      registered RAM write port
//   busy                 load in progress (WAIT or SHIFT)
//   done                 1-cycle pulse after the last bit is written
//   err_len              1-cycle pulse when start carries an illegal length
module prn_ram_loader #(
  parameter int unsigned RAM_SIZE  = 10230,
  parameter int unsigned WORD_W    = 32,
  localparam int unsigned ADDR_BITS = $clog2(RAM_SIZE)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [13:0]          length,
  input  logic [WORD_W-1:0]    s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic                 ram_din,
  output logic                 busy,
  output logic                 done,
  output logic                 err_len
);

  localparam int unsigned LEN_W  = 14;
  localparam int unsigned WCNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;     // bits written so far
  logic [WCNT_W-1:0]    wcnt_q, wcnt_d;   // index of current bit within word
  logic [WORD_W-1:0]    shreg_q, shreg_d; // remaining bits of current word
  logic                 we_q, we_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 din_q, din_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 len_ok;

  assign len_ok = (length != '0) && (32'(length) <= RAM_SIZE);

  assign s_ready  = (state_q == S_WAIT);
  assign ram_we   = we_q;
  assign ram_addr = addr_q;
  assign ram_din  = din_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err_len  = err_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      shreg_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      shreg_q <= shreg_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    shreg_d = shreg_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          busy_d = 1'b0;
          if (start) begin
            if (len_ok) begin
              len_d   = length;
              cnt_d   = '0;
              state_d = S_WAIT;
              busy_d  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (s_valid) begin
            // bit 0 goes straight to the write port; the rest is queued
            we_d    = 1'b1;
            addr_d  = ADDR_BITS'(cnt_q);
            din_d   = s_data[0];
            shreg_d = s_data >> 1;
            cnt_d   = cnt_q + LEN_W'(1);
            wcnt_d  = '0;
            state_d = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (cnt_q == len_q) begin
            // last bit is on the port now; any remaining word bits are dropped
            state_d = S_FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (wcnt_q == WCNT_W'(WORD_W - 1)) begin
            state_d = S_WAIT;
          end else begin
            we_d    = 1'b1;
            addr_d  = ADDR_BITS'(cnt_q);
            din_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q + LEN_W'(1);
            wcnt_d  = wcnt_q + WCNT_W'(1);
          end
        end
        S_FIN: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prn_ram_loader.sv
// Self-checking bench for prn_ram_loader: table of start/length cases, then
// streamed loads checked against an expected bit list derived from the words.
module tb_prn_ram_loader;

  localparam int unsigned RAM_SIZE  = 10230;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned ADDR_BITS = $clog2(RAM_SIZE);

  logic                 clk;
  logic                 resetn;
  logic                 start;
  logic                 abort;
  logic [13:0]          length;
  logic [WORD_W-1:0]    s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_addr;
  logic                 ram_din;
  logic                 busy;
  logic                 done;
  logic                 err_len;

  prn_ram_loader #(.RAM_SIZE(RAM_SIZE), .WORD_W(WORD_W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort), .length(length),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .busy(busy), .done(done), .err_len(err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;
  logic [WORD_W-1:0] words [0:511];

  typedef struct {
    logic [13:0] len;
    logic        abrt;
    logic        exp_err;
    logic        exp_busy;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_words(input int mode);
    for (int k = 0; k < 512; k++) begin
      if (mode == 0) words[k] = k[0] ? 32'h5555_5555 : 32'hAAAA_AAAA;
      else           words[k] = $urandom;
    end
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({ram_we, ram_addr, ram_din, busy, done, err_len, s_ready});
  endfunction

  // ev: 0 none, 1 abort at ev_at writes, 2 reset at ev_at writes, 3 start pulse at ev_at writes
  task automatic run_load(input int len, input bit rnd_valid, input int ev, input int ev_at,
                          input string tag);
    int  nw, widx, cyc_i, done_cnt, done_at, last_we, viol, exp_done;
    bit  fin, fired;
    nw = 0; widx = 0; cyc_i = 0; done_cnt = 0; done_at = -1; last_we = -10;
    viol = 0; fin = 1'b0; fired = 1'b0;
    length = 14'(len);
    start  = 1'b1;
    cyc();
    start  = 1'b0;
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    for (int b = 0; b < 60000 && !fin; b++) begin
      if (ram_we) begin
        if (nw < len)
          chk({tag, "_wr"}, 32'({ram_addr, ram_din}),
              32'({ADDR_BITS'(nw), words[nw / WORD_W][nw % WORD_W]}));
        else
          chk({tag, "_extra_wr"}, 32'(nw), 32'(len - 1));
        nw++;
        last_we = cyc_i;
      end
      if (s_ready && (ram_we || !busy)) viol++;
      if (done) begin
        done_cnt++;
        done_at = cyc_i;
        chk({tag, "_done_lat"}, 32'(cyc_i - last_we), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        fin = 1'b1;
      end else if (ev == 1 && !fired && nw == ev_at) begin
        fired = 1'b1;
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk({tag, "_abort_out"}, 32'({ram_we, busy, done}), 32'd0);
        fin = 1'b1;
      end else if (ev == 2 && !fired && nw == ev_at) begin
        fired  = 1'b1;
        resetn = 1'b0;
        #1;
        chk({tag, "_rst_out"}, out_vec(), 32'd0);
        cyc();
        resetn = 1'b1;
        fin = 1'b1;
      end else begin
        start   = (ev == 3 && !fired && nw == ev_at);
        if (start) begin
          fired  = 1'b1;
          length = 14'd7;
        end
        s_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        s_data  = words[widx];
        if (s_valid && s_ready) widx++;
        cyc();
        start = 1'b0;
        cyc_i++;
      end
    end
    s_valid = 1'b0;
    chk({tag, "_finished"}, 32'(fin), 32'd1);
    chk({tag, "_sready_excl"}, 32'(viol), 32'd0);
    if (ev == 1 || ev == 2) begin
      chk({tag, "_writes_before_stop"}, 32'(nw), 32'(ev_at));
      cyc();
      chk({tag, "_no_done_after_stop"}, 32'({done, busy, ram_we}), 32'd0);
    end else begin
      chk({tag, "_nwrites"}, 32'(nw), 32'(len));
      cyc();
      chk({tag, "_done_single"}, 32'({done, busy}), 32'd0);
      chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
      if (!rnd_valid && ev == 0) begin
        exp_done = (len / WORD_W) * (WORD_W + 1) +
                   ((len % WORD_W) != 0 ? (len % WORD_W) + 1 : 0);
        chk({tag, "_done_cycle"}, 32'(done_at), 32'(exp_done));
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    resetn = 1'b0; start = 1'b0; abort = 1'b0; length = '0;
    s_data = '0; s_valid = 1'b0;
    cyc();
    cyc();
    chk("reset_outputs", out_vec(), 32'd0);
    resetn = 1'b1;
    cyc();
    chk("idle_outputs", out_vec(), 32'd0);

    tbl[0] = '{len: 14'd0,     abrt: 1'b0, exp_err: 1'b1, exp_busy: 1'b0};
    tbl[1] = '{len: 14'd10231, abrt: 1'b0, exp_err: 1'b1, exp_busy: 1'b0};
    tbl[2] = '{len: 14'd16383, abrt: 1'b0, exp_err: 1'b1, exp_busy: 1'b0};
    tbl[3] = '{len: 14'd10230, abrt: 1'b0, exp_err: 1'b0, exp_busy: 1'b1};
    tbl[4] = '{len: 14'd1,     abrt: 1'b0, exp_err: 1'b0, exp_busy: 1'b1};
    tbl[5] = '{len: 14'd5,     abrt: 1'b1, exp_err: 1'b0, exp_busy: 1'b0};
    for (int i = 0; i < 6; i++) begin
      length = tbl[i].len;
      start  = 1'b1;
      abort  = tbl[i].abrt;
      cyc();
      start  = 1'b0;
      abort  = 1'b0;
      chk($sformatf("tbl%0d_err", i), 32'(err_len), 32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
      chk($sformatf("tbl%0d_we", i), 32'(ram_we), 32'd0);
      abort = busy;
      cyc();
      abort = 1'b0;
      chk($sformatf("tbl%0d_settle", i), 32'({err_len, busy, ram_we}), 32'd0);
    end

    fill_words(0);
    run_load(1023, 1'b0, 0, 0, "alt1023");
    fill_words(1);
    run_load(10230, 1'b1, 0, 0, "full_rnd");
    fill_words(1);
    run_load(1023, 1'b0, 1, 40, "abort40");
    run_load(1023, 1'b1, 0, 0, "after_abort");
    run_load(1023, 1'b0, 2, 100, "reset100");
    run_load(200, 1'b0, 0, 0, "after_reset");
    run_load(1023, 1'b1, 3, 100, "start_mid");
    run_load(1, 1'b0, 0, 0, "len1");
    run_load(64, 1'b0, 0, 0, "len64");
    for (int r = 0; r < 3; r++) begin
      fill_words(1);
      run_load(int'($urandom_range(1, 600)), 1'b1, 0, 0, $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
